float_point_add_param: RTL and testbench

FLOAT_POINT_ADD_PARAM -- requirements
Module: float_point_add_param

---
 rtl/float_point_add_param.sv | 269 ++++++++++++++++++++++++++
 tb/tb_float_point_add_param.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/float_point_add_param.sv
// Multi-cycle floating-point add/subtract with parameterised exponent and fraction widths.
// Define FP_ADD_RNE_EN for round-to-nearest-even; without it the result is truncated.
module float_point_add_param #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [EXP_W+FRAC_W:0] iA,
    input  logic [EXP_W+FRAC_W:0] iB,
    input  logic [1:0]            iOp,
    input  logic                  iValid,
    output logic                  oReady,
    output logic [EXP_W+FRAC_W:0] oF,
    output logic                  oDone,
    input  logic                  iReady,
    output logic                  oOverflow,
    output logic                  oUnderflow
);

    localparam int W  = 1 + EXP_W + FRAC_W;
    localparam int SW = FRAC_W + 4;
    localparam int EW = EXP_W + 8;
    localparam logic [EXP_W-1:0]     EXP_MAX  = '1;
    localparam logic signed [EW-1:0] EXP_TOP  = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] EXP_ZERO = '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALIGN,
        S_ADD,
        S_NORM,
        S_ROUND,
        S_DONE
    } state_t;

    function automatic logic [6:0] lzc(input logic [SW-1:0] v);
        lzc = 7'(SW);
        for (int i = 0; i < SW; i++) begin
            if (v[i]) lzc = 7'(SW - 1 - i);
        end
    endfunction

    function automatic logic rnd_inc(input logic lsb, input logic g, input logic r, input logic s);
`ifdef FP_ADD_RNE_EN
        rnd_inc = g & (r | s | lsb);
`else
        // truncation: guard, round and sticky never increment
        rnd_inc = 1'b0 & (g | r | s | lsb);
`endif
    endfunction

    state_t state_q, state_d;
    logic   live_q, live_d;

    logic [W-1:0] a_q, a_d, b_q, b_d;
    logic [1:0]   op_q, op_d;

    logic                 sgn_q, sgn_d;
    logic                 sub_q, sub_d;
    logic signed [EW-1:0] exp_q, exp_d;
    logic [SW-1:0]        big_q, big_d;
    logic [SW-1:0]        sml_q, sml_d;
    logic                 spec_q, spec_d;
    logic [W-1:0]         spec_res_q, spec_res_d;

    logic [SW:0] sum_q, sum_d;

    logic [SW-1:0]        nrm_sig_q, nrm_sig_d;
    logic signed [EW-1:0] nrm_exp_q, nrm_exp_d;
    logic                 nrm_stk_q, nrm_stk_d;

    logic [W-1:0] res_q, res_d;
    logic         ovf_q, ovf_d;
    logic         unf_q, unf_d;

    logic              a_sgn, b_sgn, a_big;
    logic              a_zero, b_zero, a_inf, b_inf;
    logic [EXP_W-1:0]  a_exp, b_exp, big_exp, sml_exp, diff;
    logic [FRAC_W-1:0] big_frc, sml_frc;
    logic [SW-1:0]     sml_sig, shifted;
    logic              stk;
    logic [6:0]        lz;
    logic              inc, rnd_cy;
    logic [FRAC_W-1:0] rnd_frc;
    logic signed [EW-1:0] rnd_exp;

    assign oReady     = (state_q == S_IDLE) && live_q;
    assign oDone      = (state_q == S_DONE);
    assign oF         = oDone ? res_q : '0;
    assign oOverflow  = oDone & ovf_q;
    assign oUnderflow = oDone & unf_q;

    always_comb begin
        state_d = state_q;
        live_d  = 1'b1;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        unique case (state_q)
            S_IDLE: begin
                if (iValid && oReady) begin
                    state_d = S_ALIGN;
                    a_d     = iA;
                    b_d     = iB;
                    op_d    = iOp;
                end
            end
            S_ALIGN: state_d = S_ADD;
            S_ADD:   state_d = S_NORM;
            S_NORM:  state_d = S_ROUND;
            S_ROUND: state_d = S_DONE;
            S_DONE:  if (iReady) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        a_sgn   = a_q[W-1];
        a_exp   = a_q[W-2:FRAC_W];
        b_sgn   = b_q[W-1] ^ (op_q == 2'b10);
        b_exp   = b_q[W-2:FRAC_W];
        a_zero  = (a_exp == '0);
        b_zero  = (b_exp == '0);
        a_inf   = (a_exp == EXP_MAX);
        b_inf   = (b_exp == EXP_MAX);
        a_big   = (a_q[W-2:0] >= b_q[W-2:0]);
        big_exp = a_big ? a_exp : b_exp;
        sml_exp = a_big ? b_exp : a_exp;
        big_frc = a_big ? a_q[FRAC_W-1:0] : b_q[FRAC_W-1:0];
        sml_frc = a_big ? b_q[FRAC_W-1:0] : a_q[FRAC_W-1:0];
        sml_sig = {1'b1, sml_frc, 3'b000};
        diff    = big_exp - sml_exp;
        if (int'(diff) > FRAC_W + 3) begin
            shifted = '0;
            stk     = (sml_exp != '0);
        end else begin
            shifted = sml_sig >> diff;
            stk     = ((shifted << diff) != sml_sig);
        end

        sgn_d      = sgn_q;
        sub_d      = sub_q;
        exp_d      = exp_q;
        big_d      = big_q;
        sml_d      = sml_q;
        spec_d     = spec_q;
        spec_res_d = spec_res_q;
        if (state_q == S_ALIGN) begin
            sgn_d = a_big ? a_sgn : b_sgn;
            sub_d = a_sgn ^ b_sgn;
            exp_d = {{(EW-EXP_W){1'b0}}, big_exp};
            big_d = {1'b1, big_frc, 3'b000};
            // sticky jams into the lowest bit so a subtraction still borrows from it
            sml_d = {shifted[SW-1:1], shifted[0] | stk};
            spec_d     = 1'b1;
            spec_res_d = '0;
            if (op_q == 2'b00 || op_q == 2'b11) begin
                spec_res_d = '0;
            end else if (a_inf && b_inf) begin
                if (a_sgn != b_sgn)
                    spec_res_d = {1'b0, EXP_MAX, 1'b1, {(FRAC_W-1){1'b0}}};
                else
                    spec_res_d = {a_sgn, EXP_MAX, {FRAC_W{1'b0}}};
            end else if (a_inf) begin
                spec_res_d = {a_sgn, EXP_MAX, {FRAC_W{1'b0}}};
            end else if (b_inf) begin
                spec_res_d = {b_sgn, EXP_MAX, {FRAC_W{1'b0}}};
            end else if (a_zero && b_zero) begin
                spec_res_d = {a_sgn & b_sgn, {(W-1){1'b0}}};
            end else if (a_zero) begin
                spec_res_d = {b_sgn, b_q[W-2:0]};
            end else if (b_zero) begin
                spec_res_d = a_q;
            end else begin
                spec_d = 1'b0;
            end
        end
    end

    always_comb begin
        sum_d = sum_q;
        if (state_q == S_ADD) begin
            if (sub_q)
                sum_d = {1'b0, big_q} - {1'b0, sml_q};
            else
                sum_d = {1'b0, big_q} + {1'b0, sml_q};
        end
    end

    always_comb begin
        nrm_sig_d = nrm_sig_q;
        nrm_exp_d = nrm_exp_q;
        nrm_stk_d = nrm_stk_q;
        lz        = lzc(sum_q[SW-1:0]);
        if (state_q == S_NORM) begin
            if (sum_q[SW]) begin
                nrm_sig_d = sum_q[SW:1];
                nrm_exp_d = exp_q + EW'(1);
                nrm_stk_d = sum_q[0];
            end else begin
                // a zero sum shifts fully out, leaving the hidden bit clear
                nrm_sig_d = sum_q[SW-1:0] << lz;
                nrm_exp_d = exp_q - $signed({{(EW-7){1'b0}}, lz});
                nrm_stk_d = 1'b0;
            end
        end
    end

    always_comb begin
        inc               = rnd_inc(nrm_sig_q[3], nrm_sig_q[2], nrm_sig_q[1],
                                    nrm_sig_q[0] | nrm_stk_q);
        {rnd_cy, rnd_frc} = {1'b0, nrm_sig_q[SW-2:3]} + {{FRAC_W{1'b0}}, inc};
        rnd_exp           = nrm_exp_q + {{(EW-1){1'b0}}, rnd_cy};

        res_d = res_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (state_q == S_ROUND) begin
            res_d = '0;
            ovf_d = 1'b0;
            unf_d = 1'b0;
            if (spec_q) begin
                res_d = spec_res_q;
            end else if (!nrm_sig_q[SW-1]) begin
                res_d = '0;
            end else if (nrm_exp_q <= EXP_ZERO) begin
                res_d = {sgn_q, {(W-1){1'b0}}};
                unf_d = 1'b1;
            end else if (rnd_exp >= EXP_TOP) begin
                res_d = {sgn_q, EXP_MAX, {FRAC_W{1'b0}}};
                ovf_d = 1'b1;
            end else begin
                res_d = {sgn_q, rnd_exp[EXP_W-1:0], rnd_frc};
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            live_q  <= live_d;
        end
    end

    always_ff @(posedge clk) begin
        a_q        <= a_d;
        b_q        <= b_d;
        op_q       <= op_d;
        sgn_q      <= sgn_d;
        sub_q      <= sub_d;
        exp_q      <= exp_d;
        big_q      <= big_d;
        sml_q      <= sml_d;
        spec_q     <= spec_d;
        spec_res_q <= spec_res_d;
        sum_q      <= sum_d;
        nrm_sig_q  <= nrm_sig_d;
        nrm_exp_q  <= nrm_exp_d;
        nrm_stk_q  <= nrm_stk_d;
        res_q      <= res_d;
        ovf_q      <= ovf_d;
        unf_q      <= unf_d;
    end

endmodule

// File: tb/tb_float_point_add_param.sv
// Directed scoreboard bench for float_point_add_param in single-precision configuration.
module tb_float_point_add_param;

    logic        clk;
    logic        resetn;
    logic [31:0] iA, iB;
    logic [1:0]  iOp;
    logic        iValid;
    logic        oReady;
    logic [31:0] oF;
    logic        oDone;
    logic        iReady;
    logic        oOverflow;
    logic        oUnderflow;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] f;
        logic        ovf;
        logic        unf;
    } exp_t;

    exp_t sb[$];

`ifdef FP_ADD_RNE_EN
    localparam logic [31:0] EXP_STICKY = 32'h3F800001;
    localparam logic [31:0] EXP_RCARRY = 32'h40000000;
`else
    localparam logic [31:0] EXP_STICKY = 32'h3F800000;
    localparam logic [31:0] EXP_RCARRY = 32'h3FFFFFFF;
`endif

    float_point_add_param #(.EXP_W(8), .FRAC_W(23)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .iA         (iA),
        .iB         (iB),
        .iOp        (iOp),
        .iValid     (iValid),
        .oReady     (oReady),
        .oF         (oF),
        .oDone      (oDone),
        .iReady     (iReady),
        .oOverflow  (oOverflow),
        .oUnderflow (oUnderflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] op, input logic [31:0] ef,
                          input logic eo, input logic eu, input int hold);
        exp_t e;
        int   n;
        @(negedge clk);
        chk({tag, "_ready"}, oReady, 1);
        iA = a; iB = b; iOp = op; iValid = 1'b1;
        e.f = ef; e.ovf = eo; e.unf = eu;
        sb.push_back(e);
        @(posedge clk); #1;
        iValid = 1'b0;
        n = 1;
        while (!oDone && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_latency"}, n, 5);
        chk({tag, "_done"}, oDone, 1);
        e = sb.pop_front();
        chk({tag, "_f"}, oF, e.f);
        chk({tag, "_ovf"}, oOverflow, e.ovf);
        chk({tag, "_unf"}, oUnderflow, e.unf);
        chk({tag, "_busy"}, oReady, 0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, "_hold_done"}, oDone, 1);
            chk({tag, "_hold_f"}, oF, e.f);
            chk({tag, "_hold_rdy"}, oReady, 0);
        end
        @(negedge clk);
        iReady = 1'b1;
        @(posedge clk); #1;
        iReady = 1'b0;
        chk({tag, "_rel_done"}, oDone, 0);
        chk({tag, "_rel_rdy"}, oReady, 1);
        chk({tag, "_rel_f"}, oF, 0);
    endtask

    initial begin
        logic seen;
        resetn = 1'b0;
        iValid = 1'b1;
        iA     = 32'h3F800000;
        iB     = 32'h3F800000;
        iOp    = 2'b01;
        iReady = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", oReady, 0);
        chk("rst_done", oDone, 0);
        chk("rst_f", oF, 0);
        chk("rst_ovf", oOverflow, 0);
        chk("rst_unf", oUnderflow, 0);
        @(negedge clk);
        iValid = 1'b0;
        resetn = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_ready", oReady, 1);
        chk("post_rst_done", oDone, 0);

        run_op("one_plus_one", 32'h3F800000, 32'h3F800000, 2'b01, 32'h40000000, 0, 0, 0);
        run_op("lz_norm",      32'h3F800000, 32'h3F7FFFFF, 2'b10, 32'h33800000, 0, 0, 0);
        run_op("sticky_rnd",   32'h3F800000, 32'h33800001, 2'b01, EXP_STICKY,   0, 0, 0);
        run_op("tie_even",     32'h3F800000, 32'h33800000, 2'b01, 32'h3F800000, 0, 0, 0);
        run_op("round_carry",  32'h3FFFFFFF, 32'h33800000, 2'b01, EXP_RCARRY,   0, 0, 0);
        run_op("far_operand",  32'h3F800000, 32'h00800000, 2'b01, 32'h3F800000, 0, 0, 0);
        run_op("overflow",     32'h7F7FFFFF, 32'h7F7FFFFF, 2'b01, 32'h7F800000, 1, 0, 0);
        run_op("cancel_sub",   32'h3FC00000, 32'h3FC00000, 2'b10, 32'h00000000, 0, 0, 0);
        run_op("cancel_add",   32'h3F800000, 32'hBF800000, 2'b01, 32'h00000000, 0, 0, 0);
        run_op("underflow",    32'h00800000, 32'h00800001, 2'b10, 32'h80000000, 0, 1, 0);
        run_op("negz_add",     32'h80000000, 32'h80000000, 2'b01, 32'h80000000, 0, 0, 0);
        run_op("negz_sub",     32'h80000000, 32'h00000000, 2'b10, 32'h80000000, 0, 0, 0);
        run_op("zero_minus_b", 32'h00000000, 32'h3F800000, 2'b10, 32'hBF800000, 0, 0, 0);
        run_op("inf_plus_fin", 32'h7F800000, 32'h3F800000, 2'b01, 32'h7F800000, 0, 0, 0);
        run_op("fin_minus_inf",32'h3F800000, 32'h7F800000, 2'b10, 32'hFF800000, 0, 0, 0);
        run_op("inf_nan",      32'h7F800000, 32'h7F800000, 2'b10, 32'h7FC00000, 0, 0, 0);
        run_op("noop_00",      32'h3F800000, 32'h3F800000, 2'b00, 32'h00000000, 0, 0, 0);
        run_op("noop_11",      32'h7F7FFFFF, 32'h7F7FFFFF, 2'b11, 32'h00000000, 0, 0, 0);
        run_op("stall",        32'h3F800000, 32'h3F800000, 2'b01, 32'h40000000, 0, 0, 10);

        @(negedge clk);
        chk("mid_ready", oReady, 1);
        iA = 32'h3F800000; iB = 32'h40000000; iOp = 2'b01; iValid = 1'b1;
        @(posedge clk); #1;
        iValid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        resetn = 1'b0;
        #1;
        chk("mid_rst_done", oDone, 0);
        chk("mid_rst_ready", oReady, 0);
        chk("mid_rst_f", oF, 0);
        @(negedge clk);
        resetn = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (oDone) seen = 1'b1;
        end
        chk("mid_rst_no_late", seen, 0);
        run_op("after_rst", 32'h3F800000, 32'h40000000, 2'b01, 32'h40400000, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
